// File: rtl/pixel_upsampler_pkg.sv
// Shared definitions for the pooling/upsampling pixel pipeline.
package pixel_upsampler_pkg;

  localparam int unsigned SCALE = 2;

  typedef enum logic {StFill, StReplay} state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefaultWidth  = 14;
  localparam int unsigned DefaultHeight = 14;

  typedef logic [cnt_width(DefaultHeight)-1:0] row_cnt_t;
  typedef logic [cnt_width(DefaultWidth)-1:0]  col_cnt_t;

endpackage

// File: rtl/pixel_upsampler_if.sv
// Pixel stream in/out bundle; master is the upstream/downstream environment, slave the upsampler.
interface pixel_upsampler_if #(
  parameter int unsigned Resolution = 8
);
  logic [Resolution-1:0] in_pixel;
  logic                  in_valid;
  logic                  in_ready;
  logic [Resolution-1:0] out_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_eol;
  logic                  out_last;

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid, out_eol, out_last
  );

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid, out_eol, out_last
  );
endinterface

// File: rtl/pixel_upsampler_line_buffer.sv
// One-row pixel store: single write port, asynchronous read port, no reset.
module pixel_upsampler_line_buffer #(
  parameter int unsigned Resolution = 8,
  parameter int unsigned Depth      = 14,
  parameter int unsigned AddrW      = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AddrW-1:0]      wr_addr_i,
  input  logic [Resolution-1:0] wr_data_i,
  input  logic [AddrW-1:0]      rd_addr_i,
  output logic [Resolution-1:0] rd_data_o
);

  logic [Resolution-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pixel_upsampler.sv
// Streaming 2x2 nearest-neighbour upsampler: each input row is emitted with every pixel doubled,
// then replayed from the line buffer.
module pixel_upsampler
  import pixel_upsampler_pkg::*;
#(
  parameter int unsigned Resolution = 8,
  parameter int unsigned InWidth    = 14,
  parameter int unsigned InHeight   = 14
) (
  input  logic             clk,
  input  logic             reset,
  pixel_upsampler_if.slave bus
);

  localparam int unsigned ColW   = cnt_width(InWidth);
  localparam int unsigned RowW   = cnt_width(InHeight);
  localparam int unsigned PhaseW = cnt_width(SCALE);

  localparam logic [ColW-1:0]   LastCol   = ColW'(InWidth - 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(InHeight - 1);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(SCALE - 1);

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [PhaseW-1:0]     phase_q, phase_d;
  logic [Resolution-1:0] hold_q, hold_d;
  logic [Resolution-1:0] out_pixel_q, out_pixel_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_eol_q, out_eol_d;
  logic                  out_last_q, out_last_d;

  logic                  load_ok, in_ready, in_xfer, advance, wr_en;
  logic                  last_col, last_row, last_phase, row_end;
  logic [Resolution-1:0] rd_data;

  assign load_ok    = !out_valid_q || bus.out_ready;
  assign in_ready   = (state_q == StFill) && (phase_q == '0) && load_ok && !reset;
  assign in_xfer    = bus.in_valid && in_ready;
  assign last_col   = (col_q == LastCol);
  assign last_row   = (row_q == LastRow);
  assign last_phase = (phase_q == LastPhase);
  assign row_end    = last_col && last_phase;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_pixel_d = out_pixel_q;
    out_valid_d = out_valid_q;
    out_eol_d   = out_eol_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    advance     = 1'b0;

    if (load_ok) begin
      unique case (state_q)
        StFill: begin
          if (phase_q == '0) begin
            if (in_xfer) begin
              hold_d      = bus.in_pixel;
              wr_en       = 1'b1;
              out_pixel_d = bus.in_pixel;
              out_valid_d = 1'b1;
              out_eol_d   = row_end;
              out_last_d  = 1'b0;
              advance     = 1'b1;
            end else begin
              out_valid_d = 1'b0;
            end
          end else begin
            out_pixel_d = hold_q;
            out_valid_d = 1'b1;
            out_eol_d   = row_end;
            out_last_d  = 1'b0;
            advance     = 1'b1;
          end
        end
        StReplay: begin
          out_pixel_d = rd_data;
          out_valid_d = 1'b1;
          out_eol_d   = row_end;
          out_last_d  = row_end && last_row;
          advance     = 1'b1;
        end
        default: ;
      endcase
    end

    // Phase is the fastest counter, then column, then the fill/replay half-row.
    if (advance) begin
      if (!last_phase) begin
        phase_d = phase_q + PhaseW'(1);
      end else begin
        phase_d = '0;
        if (!last_col) begin
          col_d = col_q + ColW'(1);
        end else begin
          col_d = '0;
          if (state_q == StFill) begin
            state_d = StReplay;
          end else begin
            state_d = StFill;
            row_d   = last_row ? '0 : row_q + RowW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFill;
      row_q       <= '0;
      col_q       <= '0;
      phase_q     <= '0;
      hold_q      <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
    end
  end

  pixel_upsampler_line_buffer #(
    .Resolution(Resolution),
    .Depth     (InWidth),
    .AddrW     (ColW)
  ) u_line_buffer (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(col_q),
    .wr_data_i(bus.in_pixel),
    .rd_addr_i(col_q),
    .rd_data_o(rd_data)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_pixel_upsampler.sv
// Directed bench for pixel_upsampler: a 2x2 instance for the small scenarios, a 14x14 instance
// for the full-size frame.
module tb_pixel_upsampler;

  localparam int Budget = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] in_data [512];
  logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pixel_upsampler_if #(.Resolution(8)) b2 ();
  pixel_upsampler_if #(.Resolution(8)) b14 ();

  pixel_upsampler #(.Resolution(8), .InWidth(2), .InHeight(2)) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (b2)
  );

  pixel_upsampler #(.Resolution(8), .InWidth(14), .InHeight(14)) u_dut14 (
    .clk  (clk),
    .reset(reset),
    .bus  (b14)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One output stream run; stop_after < 0 means run to the end of all frames.
  task automatic run_case(input string name, input bit big, input int frames, input int gap_at,
                          input int gap_len, input bit toggle, input int stop_after,
                          input int exp_bub);
    int w, h, n_in, n_out, target, fsz;
    int in_idx, out_idx, gap_left, cyc, bub, first_in, first_out;
    int f, kk, r, c;
    bit started, vin, rdy, ir, ov, eol, last, replay;
    logic [7:0] pix, px;
    w = big ? 14 : 2;
    h = big ? 14 : 2;
    fsz = 4 * w * h;
    n_in = frames * w * h;
    n_out = frames * fsz;
    target = (stop_after >= 0) ? stop_after : n_out;
    in_idx = 0; out_idx = 0; gap_left = 0; cyc = 0; bub = 0;
    first_in = -1; first_out = -1; started = 1'b0;
    while (out_idx < target && cyc < Budget) begin
      @(negedge clk);
      rdy = toggle ? rdy_pat[cyc % 4] : 1'b1;
      vin = (in_idx < n_in) && (gap_left == 0);
      px  = (in_idx < n_in) ? in_data[in_idx] : 8'd0;
      if (big) begin
        b14.in_valid = vin; b14.in_pixel = px; b14.out_ready = rdy;
      end else begin
        b2.in_valid = vin; b2.in_pixel = px; b2.out_ready = rdy;
      end
      #1;
      if (big) begin
        ir = b14.in_ready; ov = b14.out_valid; pix = b14.out_pixel;
        eol = b14.out_eol; last = b14.out_last;
      end else begin
        ir = b2.in_ready; ov = b2.out_valid; pix = b2.out_pixel;
        eol = b2.out_eol; last = b2.out_last;
      end
      if (gap_left > 0) gap_left--;
      if (vin && ir) begin
        if (first_in < 0) first_in = cyc;
        in_idx++;
        if (in_idx == gap_at) gap_left = gap_len;
      end
      if (ov) begin
        if (first_out < 0) first_out = cyc;
        f  = out_idx / fsz;
        kk = out_idx % fsz;
        r  = kk / (2 * w);
        c  = kk % (2 * w);
        check($sformatf("%s:pix%0d", name, out_idx), 32'(pix),
              32'(in_data[f * w * h + (r / 2) * w + c / 2]));
        check($sformatf("%s:eol%0d", name, out_idx), 32'(eol), 32'(c == 2 * w - 1));
        check($sformatf("%s:last%0d", name, out_idx), 32'(last),
              32'((c == 2 * w - 1) && (r == 2 * h - 1)));
        // Controller is in its replay half while these copies sit in the output register.
        replay = ((r % 2 == 0) && (c == 2 * w - 1)) || ((r % 2 == 1) && (c != 2 * w - 1));
        if (replay) check($sformatf("%s:rdy_replay%0d", name, out_idx), 32'(ir), 32'd0);
        if (rdy) out_idx++;
        started = 1'b1;
      end else if (started) begin
        bub++;
      end
      cyc++;
    end
    check({name, ":count"}, 32'(out_idx), 32'(target));
    check({name, ":latency"}, 32'(first_out), 32'(first_in + 1));
    if (exp_bub >= 0) check({name, ":bubbles"}, 32'(bub), 32'(exp_bub));
  endtask

  task automatic check_reset_state(input string name);
    check({name, ":in_ready"}, 32'(b2.in_ready), 32'd0);
    check({name, ":out_valid"}, 32'(b2.out_valid), 32'd0);
    check({name, ":out_pixel"}, 32'(b2.out_pixel), 32'd0);
    check({name, ":out_eol"}, 32'(b2.out_eol), 32'd0);
    check({name, ":out_last"}, 32'(b2.out_last), 32'd0);
  endtask

  task automatic load_basic();
    in_data[0] = 8'd10; in_data[1] = 8'd20; in_data[2] = 8'd30; in_data[3] = 8'd40;
  endtask

  initial begin
    b2.in_valid = 1'b1; b2.in_pixel = 8'd0; b2.out_ready = 1'b1;
    b14.in_valid = 1'b0; b14.in_pixel = 8'd0; b14.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    b2.in_valid = 1'b0;

    load_basic();
    run_case("basic", 1'b0, 1, -1, 0, 1'b0, -1, 0);
    run_case("stall", 1'b0, 1, -1, 0, 1'b1, -1, -1);
    run_case("gap20", 1'b0, 1, 2, 3, 1'b0, -1, 0);
    run_case("gap10", 1'b0, 1, 1, 3, 1'b0, -1, 2);

    for (int i = 0; i < 8; i++) in_data[i] = 8'(i + 1);
    run_case("b2b", 1'b0, 2, -1, 0, 1'b0, -1, 0);

    load_basic();
    run_case("partial", 1'b0, 1, -1, 0, 1'b0, 5, 0);
    @(negedge clk);
    reset = 1'b1;
    b2.in_valid = 1'b1;
    b2.out_ready = 1'b1;
    #1;
    check("midreset:in_ready_low", 32'(b2.in_ready), 32'd0);
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    b2.in_valid = 1'b0;
    run_case("after_reset", 1'b0, 1, -1, 0, 1'b0, -1, 0);

    for (int i = 0; i < 196; i++) in_data[i] = 8'(i);
    run_case("full14", 1'b1, 1, -1, 0, 1'b0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_upsampler.md
# pixel_upsampler

Streaming 2x2 nearest-neighbour upsampler, the inverse of the 2x2 average-pooling stage. It takes a raster-order stream of `in_width` x `in_height` pixels. It emits a `2*in_width` x `2*in_height` raster stream in which every input pixel appears as a 2x2 block. It sits between the downsampled-image store and the display/framebuffer writer, so pooled digits can be shown at original size. Both sides use valid/ready handshakes, and a one-row line buffer replays each row.

## Interface
- `resolution`, 8, bits per pixel
- `in_width`, 14, input pixels per row (≥1)
- `in_height`, 14, input rows per frame (≥1)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_pixel`  in  `resolution`  input pixel
- `in_valid`  in  1  `in_pixel` valid
- `in_ready`  out  1  block accepts `in_pixel` this cycle
- `out_pixel`  out  `resolution`  output pixel (registered)
- `out_valid`  out  1  `out_pixel` valid (registered)
- `out_ready`  in  1  downstream accepts `out_pixel`
- `out_eol`  out  1  marks last pixel of each output row (registered)
- `out_last`  out  1  marks last pixel of output frame (registered)

## Operation
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Output register may load when `load_ok = !out_valid | out_ready`.
- Counters: `col` 0..in_width-1, `row` 0..in_height-1, `phase` 0..1 (horizontal copy index).
- States:
  - `FILL`: current input row arrives and is emitted.
    - `in_ready = (state==FILL) & (phase==0) & load_ok & !reset`.
    - On input transfer: write `in_pixel` to `line_buf[col]` and to the hold register; load output with `in_pixel`; `phase`←1.
    - At `phase==1` with `load_ok`: load output with the hold register; `phase`←0; `col`++.
    - At `col==in_width-1`: `col`←0 and state←`REPLAY`.
  - `REPLAY`: no input accepted.
    - At each `load_ok`: load output with `line_buf[col]`.
    - `phase` and `col` advance as in `FILL`.
    - At row end: `col`←0 and state←`FILL`. `row`++, or `row`←0 if `row==in_height-1`.
- `out_eol` loads 1 with the copy where `phase==1 & col==in_width-1`, in both states.
- `out_last` loads 1 with that same copy in `REPLAY` when `row==in_height-1`.
- When `load_ok` holds but nothing is loaded (`FILL`, `phase==0`, no `in_valid`): `out_valid`←0.
- Back-to-back frames need no idle cycle. The frame after `out_last` restarts at `FILL`, row 0.
- No arithmetic on pixel data. Counters are `$clog2(in_width)` and `$clog2(in_height)` bits wide, with width-1 guarded to 1 bit.

## Timing
- Reset values:
  - `out_valid`=0, `out_pixel`=0, `out_eol`=0, `out_last`=0.
  - `in_ready`=0 while `reset` is high.
  - State `FILL`; `row`=`col`=`phase`=0.
  - `line_buf` is not cleared.
- Latency: input accepted at edge n → `out_valid` with that pixel after edge n; second copy one cycle later if `out_ready`=1.
- Throughput: 1 output/cycle with `out_ready` held high and `in_valid` continuous. The input side accepts at most 1 pixel per 2 cycles in `FILL` and none in `REPLAY`.
- A full frame with no stalls takes exactly 4·in_width·in_height cycles of `out_valid`.
- Backpressure: while `out_valid & !out_ready`, `out_pixel`, `out_eol` and `out_last` hold, and `in_ready`=0.
- Input gaps in `FILL` produce output bubbles; they never corrupt order.
- Reset mid-frame: the partial frame is discarded and the next input pixel is treated as row 0, col 0.
- `in_width==1`: every `FILL` row emits 2 pixels, then `REPLAY` emits 2.

## Structure
- Shared package holds:
  - `SCALE=2` constant.
  - State typedef `{FILL, REPLAY}`.
  - `row_cnt_t`/`col_cnt_t` width helpers used by both the pooling and upsampling blocks.
- One sub-module, `line_buffer`: `in_width` x `resolution` register array, one write port, asynchronous read port. It is instantiated once.

## Test plan
- `in_width=2`, `in_height=2`, input 10,20,30,40, `out_ready`=1:
  - Output is 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40.
  - `out_eol` on outputs 4,8,12,16; `out_last` only on 16.
- Same stimulus with `out_ready` toggling 1,0,0,1 repeating: identical sequence, and output fields stable across every stalled cycle.
- `in_valid` low for 3 cycles between inputs 20 and 30: same output order; `out_valid`=0 during the bubbles; `in_ready`=0 throughout `REPLAY`.
- Default 14x14 frame with pixel value = index, continuous handshakes: 784 outputs.
  - Output (r,c) = input (r/2,c/2).
  - `out_valid` high for 784 consecutive cycles.
- Two back-to-back 2x2 frames (1..4, 5..8): second frame starts immediately after `out_last`, with correct data.
- `reset` asserted after 5 outputs of a 2x2 frame: all outputs return to their reset values; a fresh 10,20,30,40 frame then produces the first-scenario sequence exactly.
